alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU (opcodes 0x1-0xB) among NUM_REQ requesters.
- Round-robin arbitration, valid/ready request and response handshakes.
- Registers operands, drives the ALU, captures its result and flags, and returns them to the granted requester.
- Sits between client blocks (sequencers, address generators) and the shared ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand/result width; must match ALU.
- OP_W, 4, opcode width; must match ALU.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*DATA_W  operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*DATA_W  operand B, packed the same way.
- req_op  in  NUM_REQ*OP_W  opcode, packed per requester.
- alu_in_a  out  DATA_W  to ALU operand A.
- alu_in_b  out  DATA_W  to ALU operand B.
- alu_opcode  out  OP_W  to ALU opcode.
- alu_out  in  DATA_W  ALU result.
- alu_carry  in  1  ALU carry.
- alu_zero  in  1  ALU zero flag; ignored, see Behaviour.
- rsp_valid  out  NUM_REQ  one-hot response valid to the granted requester.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_data  out  DATA_W  captured result; shared bus.
- rsp_zero  out  1  result == 0.
- rsp_carry  out  1  captured carry.
- rsp_err  out  1  illegal opcode flag; tied 0 unless the optional feature is enabled.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any req_valid is high, select the first valid requester searching from rr_ptr upward (wrap at NUM_REQ-1 to 0).
  - Assert req_ready for that requester only, combinationally, in the same cycle.
  - That cycle completes the handshake: latch a, b, op and grant index; go to EXEC.
  - No valid requests: stay in IDLE, req_ready = 0.
  - EXEC: drive alu_in_a/alu_in_b/alu_opcode from the latched registers.
  - At the end of the EXEC cycle, capture alu_out into rsp_data and alu_carry into rsp_carry.
  - rsp_zero = (captured alu_out == 0), generated locally; ALU alu_zero is never used because it is X for most nonzero values. Go to RESP.
  - RESP: rsp_valid[grant] = 1; rsp_data, rsp_zero, rsp_carry and rsp_err are held stable.
  - rsp_ready[grant] high: return to IDLE and set rr_ptr = (grant+1) mod NUM_REQ. rsp_ready from non-granted requesters is ignored.
- Latency: handshake at cycle T, rsp_valid first high at T+2. Peak throughput is one op per 3 cycles.
- Outside EXEC, alu_opcode = 0 (ALU default case); alu_in_a/alu_in_b keep their latched values.
- req_ready is 0 in EXEC and RESP. A requester that drops req_valid before being granted is simply skipped.
- Simultaneous requests: strict round-robin; a requester waits at most NUM_REQ-1 grants.
- A requester may reassert req_valid in the same cycle it accepts its response; it is then arbitrated normally in the next IDLE cycle.
- Reset values (asynchronous, any state, including mid-EXEC or mid-RESP):
  - state = IDLE, rr_ptr = 0, grant = 0.
  - All latched operands and rsp_data = 0.
  - rsp_zero, rsp_carry, rsp_err = 0.
  - req_ready, rsp_valid = 0; busy = 0; alu_opcode = 0.
  - An in-flight operation is discarded with no response.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- Defined:
  - In IDLE, an accepted opcode of 0x0 or 0xC-0xF skips EXEC and goes directly to RESP.
  - Response values: rsp_data = 0, rsp_carry = 0, rsp_zero = 0, rsp_err = 1; the ALU is not driven (alu_opcode stays 0).
  - Legal ops set rsp_err = 0.
- Undefined:
  - All opcodes go through EXEC; rsp_err is constant 0.
  - Illegal-op rsp_data is whatever the ALU returns.

Test Plan:
- Requester 0, op=0x1 (add), a=0xFF, b=0x01, rsp_ready=1 -> req_ready[0] at T; rsp_valid[0] at T+2 with rsp_data=0x00, rsp_carry=1, rsp_zero=1.
- All 4 requesters valid continuously, op=0x3 (inc), a=i -> grant order 0,1,2,3,0. Each response has rsp_data=i+1 and rsp_zero=0.
- Requester 2, op=0x2 (sub), a=0x05, b=0x05; rsp_ready held low 5 cycles -> rsp_valid[2] and rsp_data=0x00 stable throughout, busy=1, req_ready all 0; IDLE one cycle after rsp_ready rises.
- Requester 1, op=0x9 (shl), a=0x81; rst pulsed during EXEC -> all outputs return to reset values immediately, no response. Next request is then served normally: rsp_data=0x02, rsp_carry=1.
- ALU_ARB_OPCHECK_EN defined, op=0xE -> rsp_valid at T+1, rsp_err=1, rsp_data=0, alu_opcode never nonzero. Undefined: rsp_err=0, rsp_valid at T+2.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin arbiter sharing one combinational ALU among NUM_REQ
//            requesters. Optional macro ALU_ARB_OPCHECK_EN flags illegal ops.
// Revision : 1.0
// ============================================================================
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]         alu_in_a,
  output logic [DATA_W-1:0]         alu_in_b,
  output logic [OP_W-1:0]           alu_opcode,
  input  logic [DATA_W-1:0]         alu_out,
  input  logic                      alu_carry,
  input  logic                      alu_zero,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_zero,
  output logic                      rsp_carry,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_grant;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_zero;
  logic                r_rsp_carry;

  logic                w_found;
  logic [IDX_W-1:0]    w_sel;
  logic [IDX_W:0]      w_cand;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [OP_W-1:0]     w_sel_op;
  logic                w_accept;
  logic                w_rsp_done;
  logic [IDX_W-1:0]    w_ptr_next;
  logic [NUM_REQ-1:0]  w_req_ready;
  logic [NUM_REQ-1:0]  w_rsp_valid;
  logic                w_unused;

  // The ALU zero flag is unreliable; zero is derived from the captured result.
  assign w_unused = alu_zero;

  // First valid requester at or after r_rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(NUM_REQ))
        w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
      if (!w_found && req_valid[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[IDX_W-1:0];
      end
    end
  end

  assign w_sel_a    = req_a[int'(w_sel)*DATA_W +: DATA_W];
  assign w_sel_b    = req_b[int'(w_sel)*DATA_W +: DATA_W];
  assign w_sel_op   = req_op[int'(w_sel)*OP_W +: OP_W];
  assign w_ptr_next = (r_grant == IDX_W'(NUM_REQ-1)) ? '0 : r_grant + 1'b1;

`ifdef ALU_ARB_OPCHECK_EN
  localparam logic [OP_W-1:0] c_op_last = OP_W'(11);
  logic w_illegal;
  logic r_rsp_err;
  assign w_illegal = (w_sel_op == '0) || (w_sel_op > c_op_last);
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = '0;
    w_rsp_valid = '0;
    w_accept    = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_req_ready[w_sel] = 1'b1;
          w_accept           = 1'b1;
`ifdef ALU_ARB_OPCHECK_EN
          w_next = w_illegal ? S_RESP : S_EXEC;
`else
          w_next = S_EXEC;
`endif
        end
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        w_rsp_valid[r_grant] = 1'b1;
        if (rsp_ready[r_grant]) begin
          w_next     = S_IDLE;
          w_rsp_done = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_carry <= 1'b0;
    end else begin
      if (w_accept) begin
        r_grant <= w_sel;
        r_a     <= w_sel_a;
        r_b     <= w_sel_b;
        r_op    <= w_sel_op;
`ifdef ALU_ARB_OPCHECK_EN
        if (w_illegal) begin
          r_rsp_data  <= '0;
          r_rsp_zero  <= 1'b0;
          r_rsp_carry <= 1'b0;
        end
`endif
      end
      if (r_state == S_EXEC) begin
        r_rsp_data  <= alu_out;
        r_rsp_carry <= alu_carry;
        r_rsp_zero  <= (alu_out == '0);
      end
      if (w_rsp_done)
        r_rr_ptr <= w_ptr_next;
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_rsp_err <= 1'b0;
    else if (w_accept) r_rsp_err <= w_illegal;
  end
`endif

  assign req_ready  = w_req_ready;
  assign rsp_valid  = w_rsp_valid;
  assign alu_in_a   = r_a;
  assign alu_in_b   = r_b;
  assign alu_opcode = (r_state == S_EXEC) ? r_op : '0;
  assign rsp_data   = r_rsp_data;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_carry  = r_rsp_carry;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Scoreboard bench for alu_arbiter with a behavioural ALU model.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_a, req_b;
  logic [N*OW-1:0] req_op;
  logic [DW-1:0]   alu_in_a, alu_in_b, alu_out, rsp_data;
  logic [OW-1:0]   alu_opcode;
  logic            alu_carry, alu_zero, rsp_zero, rsp_carry, rsp_err, busy;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Returns {carry, result}.
  function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0:    alu_ref = 9'h000;
      4'h1:    alu_ref = {1'b0, a} + {1'b0, b};
      4'h2:    alu_ref = {1'b0, a} - {1'b0, b};
      4'h3:    alu_ref = {1'b0, a} + 9'h001;
      4'h9:    alu_ref = {a[7], a[6:0], 1'b0};
      default: alu_ref = {1'b0, a ^ b};
    endcase
  endfunction

  // Zero flag driven inverted so any reliance on it by the DUT is exposed.
  assign {alu_carry, alu_out} = alu_ref(alu_opcode, alu_in_a, alu_in_b);
  assign alu_zero = (alu_out != 8'h00);

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       carry;
    logic       zero;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_rsp    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  always @(posedge rst) sb.delete();

  always @(negedge clk) begin
    if (!rst) begin
      check_eq("rdy_onehot0", 32'($onehot0(req_ready)), 32'd1);
      check_eq("vld_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t       e;
          logic [3:0] op;
          logic [8:0] r;
          op      = req_op[i*OW +: OW];
          r       = alu_ref(op, req_a[i*DW +: DW], req_b[i*DW +: DW]);
          e.idx   = i;
          e.data  = r[7:0];
          e.carry = r[8];
          e.zero  = (r[7:0] == 8'h00);
          e.err   = 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
          if (op == 4'h0 || op > 4'hB) begin
            e.data = 8'h00; e.carry = 1'b0; e.zero = 1'b0; e.err = 1'b1;
          end
`endif
          sb.push_back(e);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            n_rsp++;
            check_eq("rsp_idx",   32'(i),         32'(e.idx));
            check_eq("rsp_data",  32'(rsp_data),  32'(e.data));
            check_eq("rsp_carry", 32'(rsp_carry), 32'(e.carry));
            check_eq("rsp_zero",  32'(rsp_zero),  32'(e.zero));
            check_eq("rsp_err",   32'(rsp_err),   32'(e.err));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    req_valid[i]       = 1'b1;
    req_op[i*OW +: OW] = op;
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int order[$];
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy",    32'(busy),       32'd0);
    check_eq("rst_ready",   32'(req_ready),  32'd0);
    check_eq("rst_valid",   32'(rsp_valid),  32'd0);
    check_eq("rst_opcode",  32'(alu_opcode), 32'd0);
    check_eq("rst_data",    32'(rsp_data),   32'd0);
    check_eq("rst_flags",   32'({rsp_zero, rsp_carry, rsp_err}), 32'd0);
    step();
    rst = 1'b0;

    // add with carry-out and zero result, requester 0
    rsp_ready = '1;
    set_req(0, 4'h1, 8'hFF, 8'h01);
    @(negedge clk);
    check_eq("t1_ready_T",  32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    @(negedge clk);
    check_eq("t1_busy_exec", 32'(busy),       32'd1);
    check_eq("t1_opcode",    32'(alu_opcode), 32'h1);
    check_eq("t1_in_a",      32'(alu_in_a),   32'hFF);
    check_eq("t1_valid_T1",  32'(rsp_valid),  32'd0);
    step();
    @(negedge clk);
    check_eq("t1_valid_T2",  32'(rsp_valid),  32'b0001);
    check_eq("t1_data",      32'(rsp_data),   32'h00);
    check_eq("t1_carry",     32'(rsp_carry),  32'd1);
    check_eq("t1_zero",      32'(rsp_zero),   32'd1);
    check_eq("t1_op_resp",   32'(alu_opcode), 32'd0);
    step();
    @(negedge clk);
    check_eq("t1_idle",      32'(busy),       32'd0);

    // round robin with all requesters continuously valid
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 4'h3, 8'(i), 8'h00);
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0) order.push_back($clog2(req_ready));
      if (order.size() < 5) step();
    end
    check_eq("t2_grants", 32'(order.size()), 32'd5);
    for (int k = 0; k < order.size(); k++)
      check_eq("t2_order", 32'(order[k]), 32'(k % N));
    step();
    req_valid = '0;
    repeat (3) step();

    // held response with others pushing valid/ready
    rsp_ready = '0;
    set_req(2, 4'h2, 8'h05, 8'h05);
    @(negedge clk);
    check_eq("t3_ready_T", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    step();
    req_valid = 4'b1011;
    rsp_ready = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("t3_hold_valid", 32'(rsp_valid), 32'b0100);
      check_eq("t3_hold_data",  32'(rsp_data),  32'h00);
      check_eq("t3_hold_busy",  32'(busy),      32'd1);
      check_eq("t3_hold_ready", 32'(req_ready), 32'd0);
      step();
    end
    req_valid = '0;
    rsp_ready = 4'b0100;
    @(negedge clk);
    check_eq("t3_accept_valid", 32'(rsp_valid), 32'b0100);
    step();
    @(negedge clk);
    check_eq("t3_idle_busy",  32'(busy),      32'd0);
    check_eq("t3_idle_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = '1;
    step();

    // reset during EXEC discards the operation
    set_req(1, 4'h9, 8'h81, 8'h00);
    @(negedge clk);
    check_eq("t4_ready_T", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    @(negedge clk);
    check_eq("t4_opcode", 32'(alu_opcode), 32'h9);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t4_rst_busy",   32'(busy),       32'd0);
    check_eq("t4_rst_opcode", 32'(alu_opcode), 32'd0);
    check_eq("t4_rst_in_a",   32'(alu_in_a),   32'd0);
    check_eq("t4_rst_valid",  32'(rsp_valid),  32'd0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("t4_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    set_req(1, 4'h9, 8'h81, 8'h00);
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    check_eq("t4_valid", 32'(rsp_valid), 32'b0010);
    check_eq("t4_data",  32'(rsp_data),  32'h02);
    check_eq("t4_carry", 32'(rsp_carry), 32'd1);
    step();

    // illegal opcode 0xE, requester 3
    set_req(3, 4'hE, 8'h12, 8'h34);
    @(negedge clk);
    check_eq("t5_ready_T", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    @(negedge clk);
`ifdef ALU_ARB_OPCHECK_EN
    check_eq("t5_valid_T1", 32'(rsp_valid),  32'b1000);
    check_eq("t5_err",      32'(rsp_err),    32'd1);
    check_eq("t5_data",     32'(rsp_data),   32'h00);
    check_eq("t5_opcode",   32'(alu_opcode), 32'd0);
    step();
    @(negedge clk);
    check_eq("t5_idle",     32'(busy),       32'd0);
`else
    check_eq("t5_valid_T1", 32'(rsp_valid),  32'd0);
    check_eq("t5_opcode",   32'(alu_opcode), 32'hE);
    step();
    @(negedge clk);
    check_eq("t5_valid_T2", 32'(rsp_valid),  32'b1000);
    check_eq("t5_err",      32'(rsp_err),    32'd0);
    check_eq("t5_data",     32'(rsp_data),   32'h26);
`endif
    repeat (3) step();

    check_eq("sb_empty",  32'(sb.size()), 32'd0);
    check_eq("rsp_count", 32'(n_rsp),     32'd9);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
